// File: rtl/ternary_radix_converter_if.sv
// Request/response bundle for the binary <-> balanced-ternary converter.
// Trits use a 2-bit code: 00 zero, 01 +1, 10 -1, 11 invalid.
interface ternary_radix_converter_if #(
   parameter int N_TRITS = 27,
   parameter int BIN_W   = 48
);
   logic                           in_valid;
   logic                           in_ready;
   logic                           mode;
   logic signed [BIN_W-1:0]        bin_in;
   logic        [N_TRITS-1:0][1:0] tern_in;
   logic                           abort;
   logic                           out_valid;
   logic                           out_ready;
   logic                           mode_out;
   logic signed [BIN_W-1:0]        bin_out;
   logic        [N_TRITS-1:0][1:0] tern_out;
   logic                           err;

   modport master (
      output in_valid, mode, bin_in, tern_in, abort, out_ready,
      input  in_ready, out_valid, mode_out, bin_out, tern_out, err
   );

   modport slave (
      input  in_valid, mode, bin_in, tern_in, abort, out_ready,
      output in_ready, out_valid, mode_out, bin_out, tern_out, err
   );
endinterface

// File: rtl/ternary_radix_converter.sv
// Sequential two-way converter between two's-complement binary and
// balanced-ternary trit vectors, one trit per cycle.
// mode 0: binary -> ternary, LSB trit first.
// mode 1: ternary -> binary, MSB trit first (Horner accumulation).
module ternary_radix_converter #(
   parameter int N_TRITS = 27,
   parameter int BIN_W   = 48
) (
   input logic                      clk,
   input logic                      rst_n,
   ternary_radix_converter_if.slave bus
);
   localparam logic [1:0] T_ZERO    = 2'b00;
   localparam logic [1:0] T_POS_ONE = 2'b01;
   localparam logic [1:0] T_NEG_ONE = 2'b10;
   localparam logic [1:0] T_INVALID = 2'b11;

   localparam int            CW   = $clog2(N_TRITS);
   localparam logic [CW-1:0] LAST = CW'(N_TRITS - 1);

   // Constants at the working widths: BIN_W+1 for division, BIN_W for the accumulator.
   localparam logic signed [BIN_W:0]   W_ONE   = {{BIN_W{1'b0}}, 1'b1};
   localparam logic signed [BIN_W:0]   W_TWO   = {{(BIN_W-1){1'b0}}, 2'b10};
   localparam logic signed [BIN_W:0]   W_THREE = {{(BIN_W-1){1'b0}}, 2'b11};
   localparam logic signed [BIN_W-1:0] B_ONE   = {{(BIN_W-1){1'b0}}, 1'b1};
   localparam logic signed [BIN_W-1:0] B_THREE = {{(BIN_W-2){1'b0}}, 2'b11};

   // 2^(BIN_W-1)-1 >= (3^N-1)/2 reduces to 2^BIN_W > 3^N, since 3^N is odd.
   function automatic logic [255:0] pow3(input int n);
      logic [255:0] p;
      p = 256'd1;
      for (int i = 0; i < n; i++) p = p * 256'd3;
      return p;
   endfunction

   localparam logic [255:0] TERN_SPAN = pow3(N_TRITS);
   localparam logic [255:0] BIN_SPAN  = 256'd1 << BIN_W;

   generate
      if (BIN_SPAN < TERN_SPAN) begin : g_range_check
         $error("BIN_W too narrow to hold the full balanced-ternary range of N_TRITS");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                     state, state_nxt;
   logic   [CW-1:0]            cnt;
   logic                       mode_r;
   logic signed [BIN_W:0]      temp;      // B2T remainder, one bit wider so -2^(BIN_W-1) never wraps
   logic signed [BIN_W-1:0]    acc;       // T2B accumulator
   logic                       inv;       // T2B saw an invalid trit so far
   logic [N_TRITS-1:0][1:0]    vec;       // B2T result under construction / T2B operand

   logic signed [BIN_W:0]      rem, step, temp_nxt;
   logic [1:0]                 digit, cur;
   logic [CW-1:0]              idx;
   logic signed [BIN_W-1:0]    tval, acc_nxt;
   logic                       inv_nxt;
   logic [N_TRITS-1:0][1:0]    vec_nxt;

   logic                       mode_q, err_q;
   logic signed [BIN_W-1:0]    bin_q;
   logic [N_TRITS-1:0][1:0]    tern_q;

   logic accept, last;

   // Abort in IDLE wins over a request; nothing is latched then.
   assign accept = (state == IDLE) && bus.in_valid && !bus.abort;
   assign last   = (state == CONV) && (cnt == LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: fixed N_TRITS-cycle CONV, DONE holds until the consumer takes it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = CONV;
         CONV: begin
            if (bus.abort)           state_nxt = IDLE;
            else if (cnt == LAST)    state_nxt = DONE;
         end
         DONE: begin
            if (bus.abort || bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes.
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
   end

   // One conversion step for each direction, computed from the current working state.
   always_comb begin
      // Floor-mod 3: truncating remainder, then lift negatives into 0..2.
      rem = temp % W_THREE;
      if (rem[BIN_W]) rem = rem + W_THREE;
      digit = T_ZERO;
      step  = '0;
      if (rem == W_ONE) begin
         digit = T_POS_ONE;
         step  = W_ONE;
      end else if (rem == W_TWO) begin
         digit = T_NEG_ONE;
         step  = -W_ONE;
      end
      temp_nxt     = (temp - step) / W_THREE;   // exact division
      vec_nxt      = vec;
      vec_nxt[cnt] = digit;

      idx  = LAST - cnt;
      cur  = vec[idx];
      tval = '0;
      if (cur == T_POS_ONE)      tval = B_ONE;
      else if (cur == T_NEG_ONE) tval = -B_ONE;
      acc_nxt = acc * B_THREE + tval;
      inv_nxt = inv | (cur == T_INVALID);
   end

   // Working registers: latch operands on accept, advance one trit per CONV cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         mode_r <= 1'b0;
         temp   <= '0;
         acc    <= '0;
         inv    <= 1'b0;
         vec    <= '0;
      end else if (accept) begin
         cnt    <= '0;
         mode_r <= bus.mode;
         temp   <= {bus.bin_in[BIN_W-1], bus.bin_in};
         acc    <= '0;
         inv    <= 1'b0;
         vec    <= bus.mode ? bus.tern_in : '0;
      end else if (state == CONV) begin
         cnt <= cnt + CW'(1);
         if (mode_r) begin
            acc <= acc_nxt;
            inv <= inv_nxt;
         end else begin
            temp <= temp_nxt;
            vec  <= vec_nxt;
         end
      end
   end

   // Result registers load only on the final trit (unless aborted) and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
         err_q  <= 1'b0;
         bin_q  <= '0;
         tern_q <= '0;
      end else if (last && !bus.abort) begin
         mode_q <= mode_r;
         if (mode_r) begin
            bin_q  <= inv_nxt ? '0 : acc_nxt;
            tern_q <= '0;
            err_q  <= inv_nxt;
         end else begin
            bin_q  <= '0;
            tern_q <= vec_nxt;
            err_q  <= (temp_nxt != '0);
         end
      end
   end

   assign bus.mode_out = mode_q;
   assign bus.err      = err_q;
   assign bus.bin_out  = bin_q;
   assign bus.tern_out = tern_q;
endmodule

// File: tb/tb_ternary_radix_converter.sv
// Randomized self-checking bench: a small instance (8 trits) for directed and
// protocol scenarios, the default instance for round-trip conversion.
module tb_ternary_radix_converter;
   localparam int SN = 8;
   localparam int SW = 16;
   localparam int BN = 27;
   localparam int BW = 48;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ternary_radix_converter_if #(.N_TRITS(SN), .BIN_W(SW)) sb ();
   ternary_radix_converter_if #(.N_TRITS(BN), .BIN_W(BW)) db ();

   ternary_radix_converter #(.N_TRITS(SN), .BIN_W(SW)) u_small (.clk(clk), .rst_n(rst_n), .bus(sb));
   ternary_radix_converter #(.N_TRITS(BN), .BIN_W(BW)) u_big   (.clk(clk), .rst_n(rst_n), .bus(db));

   // ---------------- reference model ----------------
   function automatic longint p3(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 3;
      return p;
   endfunction

   // Low n balanced trits of v: shift by (3^n-1)/2, take plain base-3 digits mod 3^n, digit-1.
   function automatic logic [53:0] b2t_ref(input longint v, input int n);
      logic [53:0] r = '0;
      longint p = p3(n);
      longint u = (v + (p - 1) / 2) % p;
      longint d;
      if (u < 0) u = u + p;
      for (int i = 0; i < n; i++) begin
         d = u % 3;
         u = u / 3;
         r[2*i +: 2] = (d == 0) ? 2'b10 : (d == 1) ? 2'b00 : 2'b01;
      end
      return r;
   endfunction

   function automatic bit ovf_ref(input longint v, input int n);
      longint m = (p3(n) - 1) / 2;
      return (v > m) || (v < -m);
   endfunction

   // Weighted sum of trits; any 11 code marks the vector invalid and yields 0.
   task automatic t2b_ref(input logic [53:0] t, input int n, output longint v, output bit inv);
      longint w = 1;
      logic [1:0] c;
      v = 0;
      inv = 1'b0;
      for (int i = 0; i < n; i++) begin
         c = t[2*i +: 2];
         if (c == 2'b01) v = v + w;
         else if (c == 2'b10) v = v - w;
         else if (c == 2'b11) inv = 1'b1;
         w = w * 3;
      end
      if (inv) v = 0;
   endtask

   // ---------------- drivers (called at posedge+1) ----------------
   task automatic run_small(input logic md, input longint bv, input logic [15:0] tv, output int lat);
      sb.mode = md; sb.bin_in = bv[SW-1:0]; sb.tern_in = tv; sb.in_valid = 1'b1;
      @(posedge clk); #1 sb.in_valid = 1'b0;
      lat = -1;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (sb.out_valid) begin lat = c; break; end
      end
   endtask

   task automatic run_big(input logic md, input longint bv, input logic [53:0] tv, output int lat);
      db.mode = md; db.bin_in = bv[BW-1:0]; db.tern_in = tv; db.in_valid = 1'b1;
      @(posedge clk); #1 db.in_valid = 1'b0;
      lat = -1;
      for (int c = 0; c <= 60; c++) begin
         @(negedge clk);
         if (db.out_valid) begin lat = c; break; end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++; if (sb.in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", sb.in_ready); end
      n_vec++; if (sb.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", sb.out_valid); end
      n_vec++; if ({sb.err, sb.mode_out} !== 2'b00) begin n_bad++; $display("FAIL reset_err_mode got=%b%b exp=00", sb.err, sb.mode_out); end
      n_vec++; if (sb.bin_out !== '0 || sb.tern_out !== '0) begin n_bad++; $display("FAIL reset_data got=%h/%h exp=0/0", sb.bin_out, sb.tern_out); end
      n_vec++; if (db.in_ready !== 1'b1 || db.out_valid !== 1'b0 || db.tern_out !== '0) begin n_bad++; $display("FAIL reset_big rdy=%b vld=%b tern=%h", db.in_ready, db.out_valid, db.tern_out); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_b2t_small();
      longint vals[$] = '{5, -5, 3280, -3280, 3281, -3281, 0, 1, -1, -32768, 32767};
      logic [53:0] exp;
      int lat;
      repeat (8) vals.push_back(longint'($urandom_range(0, 8000)) - 4000);
      foreach (vals[i]) begin
         run_small(1'b0, vals[i], 16'h0, lat);
         exp = b2t_ref(vals[i], SN);
         n_vec++; if (lat !== SN) begin n_bad++; $display("FAIL b2t_latency v=%0d got=%0d exp=%0d", vals[i], lat, SN); end
         n_vec++; if (sb.tern_out !== exp[15:0]) begin n_bad++; $display("FAIL b2t_tern v=%0d got=%h exp=%h", vals[i], sb.tern_out, exp[15:0]); end
         n_vec++; if (sb.err !== ovf_ref(vals[i], SN)) begin n_bad++; $display("FAIL b2t_err v=%0d got=%b exp=%b", vals[i], sb.err, ovf_ref(vals[i], SN)); end
         n_vec++; if (sb.bin_out !== '0 || sb.mode_out !== 1'b0) begin n_bad++; $display("FAIL b2t_unused v=%0d bin=%h mode=%b exp=0/0", vals[i], sb.bin_out, sb.mode_out); end
         n_vec++; if (sb.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2t_in_ready_done got=%b exp=0", sb.in_ready); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_t2b_small();
      logic [15:0] vecs[$] = '{16'h5555, 16'h55D5, 16'hAAAA, 16'h0000};
      logic [15:0] t;
      longint ev;
      bit inv;
      int lat;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < SN; i++) t[2*i +: 2] = 2'($urandom_range(0, 2));
         if (k % 3 == 0) t[2*$urandom_range(0, SN-1) +: 2] = 2'b11;
         vecs.push_back(t);
      end
      foreach (vecs[i]) begin
         run_small(1'b1, 0, vecs[i], lat);
         t2b_ref({38'h0, vecs[i]}, SN, ev, inv);
         n_vec++; if (lat !== SN) begin n_bad++; $display("FAIL t2b_latency t=%h got=%0d exp=%0d", vecs[i], lat, SN); end
         n_vec++; if (sb.bin_out !== ev[SW-1:0]) begin n_bad++; $display("FAIL t2b_bin t=%h got=%0d exp=%0d", vecs[i], sb.bin_out, ev); end
         n_vec++; if (sb.err !== inv) begin n_bad++; $display("FAIL t2b_err t=%h got=%b exp=%b", vecs[i], sb.err, inv); end
         n_vec++; if (sb.tern_out !== '0 || sb.mode_out !== 1'b1) begin n_bad++; $display("FAIL t2b_unused t=%h tern=%h mode=%b exp=0/1", vecs[i], sb.tern_out, sb.mode_out); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] t0;
      logic [53:0] exp;
      int lat;
      sb.out_ready = 1'b0;
      run_small(1'b0, 5, 16'h0, lat);
      exp = b2t_ref(5, SN);
      t0 = sb.tern_out;
      n_vec++; if (t0 !== exp[15:0]) begin n_bad++; $display("FAIL bp_first got=%h exp=%h", t0, exp[15:0]); end
      @(posedge clk); #1;
      sb.mode = 1'b1; sb.tern_in = 16'h5555; sb.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_vec++; if (sb.out_valid !== 1'b1 || sb.in_ready !== 1'b0 || sb.tern_out !== exp[15:0] || sb.err !== 1'b0)
            begin n_bad++; $display("FAIL bp_hold c=%0d vld=%b rdy=%b tern=%h err=%b exp=1/0/%h/0", c, sb.out_valid, sb.in_ready, sb.tern_out, sb.err, exp[15:0]); end
         @(posedge clk); #1;
      end
      sb.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_vec++; if (sb.in_ready !== 1'b1 || sb.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release rdy=%b vld=%b exp=1/0", sb.in_ready, sb.out_valid); end
      @(posedge clk); @(negedge clk);
      sb.in_valid = 1'b0;
      n_vec++; if (sb.in_ready !== 1'b0 || sb.tern_out !== exp[15:0]) begin n_bad++; $display("FAIL bp_accept rdy=%b tern=%h exp=0/%h", sb.in_ready, sb.tern_out, exp[15:0]); end
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (sb.out_valid) begin lat = c; break; end
      end
      n_vec++; if (lat !== SN) begin n_bad++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, SN); end
      n_vec++; if (sb.bin_out !== 16'sd3280 || sb.mode_out !== 1'b1) begin n_bad++; $display("FAIL bp_second_result got=%0d/%b exp=3280/1", sb.bin_out, sb.mode_out); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      bit seen;
      int lat;
      logic [53:0] exp;
      sb.mode = 1'b1; sb.tern_in = 16'h5555; sb.in_valid = 1'b1;
      @(posedge clk); #1 sb.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 sb.abort = 1'b1;
      @(posedge clk); #1 sb.abort = 1'b0;
      @(negedge clk);
      n_vec++; if (sb.in_ready !== 1'b1 || sb.out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_idle rdy=%b vld=%b exp=1/0", sb.in_ready, sb.out_valid); end
      seen = 1'b0;
      repeat (12) begin @(negedge clk); seen |= sb.out_valid; end
      n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_result out_valid_seen=%b exp=0", seen); end
      @(posedge clk); #1;
      sb.in_valid = 1'b1; sb.abort = 1'b1; sb.mode = 1'b0; sb.bin_in = 16'sd7;
      @(posedge clk); #1 sb.in_valid = 1'b0; sb.abort = 1'b0;
      @(negedge clk);
      n_vec++; if (sb.in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_priority rdy=%b exp=1", sb.in_ready); end
      @(posedge clk); #1;
      run_small(1'b0, -7, 16'h0, lat);
      exp = b2t_ref(-7, SN);
      n_vec++; if (lat !== SN || sb.tern_out !== exp[15:0]) begin n_bad++; $display("FAIL abort_recover lat=%0d tern=%h exp=%0d/%h", lat, sb.tern_out, SN, exp[15:0]); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit seen;
      sb.mode = 1'b0; sb.bin_in = 16'sd100; sb.in_valid = 1'b1;
      @(posedge clk); #1 sb.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_vec++; if (sb.in_ready !== 1'b1 || sb.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid rdy=%b vld=%b exp=1/0", sb.in_ready, sb.out_valid); end
      n_vec++; if (sb.tern_out !== '0 || sb.mode_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_regs tern=%h mode=%b exp=0/0", sb.tern_out, sb.mode_out); end
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin @(negedge clk); seen |= sb.out_valid; end
      n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_result out_valid_seen=%b exp=0", seen); end
      @(posedge clk); #1;
   endtask

   task automatic test_roundtrip();
      longint m = (p3(BN) - 1) / 2;
      longint vals[$] = '{m, -m, 0};
      longint unsigned r;
      logic [53:0] exp, back;
      longint v;
      int lat;
      for (int k = 0; k < 1000; k++) begin
         r = {$urandom(), $urandom()};
         vals.push_back(longint'(r % longint'(2 * m + 1)) - m);
      end
      foreach (vals[i]) begin
         v = vals[i];
         run_big(1'b0, v, '0, lat);
         exp = b2t_ref(v, BN);
         back = db.tern_out;
         n_vec++; if (lat !== BN || back !== exp || db.err !== 1'b0) begin n_bad++; $display("FAIL rt_b2t v=%0d lat=%0d tern=%h err=%b exp=%0d/%h/0", v, lat, back, db.err, BN, exp); end
         @(posedge clk); #1;
         run_big(1'b1, 0, back, lat);
         n_vec++; if (lat !== BN || db.bin_out !== v[BW-1:0] || db.err !== 1'b0) begin n_bad++; $display("FAIL rt_t2b v=%0d lat=%0d got=%0d err=%b", v, lat, db.bin_out, db.err); end
         @(posedge clk); #1;
      end
      v = -(longint'(1) <<< (BW - 1));
      run_big(1'b0, v, '0, lat);
      exp = b2t_ref(v, BN);
      n_vec++; if (db.err !== 1'b1 || db.tern_out !== exp) begin n_bad++; $display("FAIL rt_min_neg err=%b tern=%h exp=1/%h", db.err, db.tern_out, exp); end
      @(posedge clk); #1;
      run_big(1'b0, m + 1, '0, lat);
      n_vec++; if (db.err !== 1'b1) begin n_bad++; $display("FAIL rt_max_plus1 err=%b exp=1", db.err); end
      @(posedge clk); #1;
   endtask

   initial begin
      sb.in_valid = 1'b0; sb.mode = 1'b0; sb.bin_in = '0; sb.tern_in = '0; sb.abort = 1'b0; sb.out_ready = 1'b1;
      db.in_valid = 1'b0; db.mode = 1'b0; db.bin_in = '0; db.tern_in = '0; db.abort = 1'b0; db.out_ready = 1'b1;
      test_reset();
      test_b2t_small();
      test_t2b_small();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_roundtrip();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
